// File: rtl/decode_hamming.sv
// Registered SECDED decoder for a 12-bit extended Hamming word (7 data bits), with saturating event counters.
// Single-bit correction of the data is enabled by DECODE_HAMMING_CORRECT_EN; otherwise the block only detects and reports errors.
module decode_hamming (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [12:1] in_data,
    output logic        out_valid,
    output logic [7:1]  decode_data,
    output logic [3:0]  C,
    output logic        single_error,
    output logic        double_error,
    output logic [7:0]  sec_count,
    output logic [7:0]  ded_count
);

    logic       c1;
    logic       c2;
    logic       c4;
    logic       c8;
    logic       parity;
    logic [3:0] syndrome;
    logic       syn_zero;
    logic       syn_in_range;
    logic       err_single;
    logic       err_double;
    logic [7:1] data_raw;
    logic [7:1] data_out;

    assign c1 = in_data[1] ^ in_data[3] ^ in_data[5] ^ in_data[7] ^ in_data[9] ^ in_data[11];
    assign c2 = in_data[2] ^ in_data[3] ^ in_data[6] ^ in_data[7] ^ in_data[10] ^ in_data[11];
    assign c4 = in_data[4] ^ in_data[5] ^ in_data[6] ^ in_data[7];
    assign c8 = in_data[8] ^ in_data[9] ^ in_data[10] ^ in_data[11];

    assign syndrome = {c8, c4, c2, c1};
    assign parity   = ^in_data;

    assign syn_zero     = (syndrome == 4'd0);
    assign syn_in_range = !syn_zero && (syndrome <= 4'd11);

    // A parity mismatch with syndrome 12..15 points outside the word, so it cannot be a single flip.
    assign err_single = parity && (syn_zero || syn_in_range);
    assign err_double = (!parity && !syn_zero) || (parity && !syn_zero && !syn_in_range);

    assign data_raw = {in_data[11], in_data[10], in_data[9], in_data[7],
                       in_data[6], in_data[5], in_data[3]};

`ifdef DECODE_HAMMING_CORRECT_EN
    logic [7:1] data_mask;

    // Only data positions matter here; a flipped check bit leaves the data intact.
    assign data_mask = {7{parity}} & {(syndrome == 4'd11), (syndrome == 4'd10),
                                      (syndrome == 4'd9),  (syndrome == 4'd7),
                                      (syndrome == 4'd6),  (syndrome == 4'd5),
                                      (syndrome == 4'd3)};
    assign data_out  = data_raw ^ data_mask;
`else
    assign data_out = data_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            decode_data  <= '0;
            C            <= '0;
            single_error <= 1'b0;
            double_error <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                decode_data  <= data_out;
                C            <= syndrome;
                single_error <= err_single;
                double_error <= err_double;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (in_valid) begin
            if (err_single && (sec_count != 8'hFF)) begin
                sec_count <= sec_count + 8'd1;
            end
            if (err_double && (ded_count != 8'hFF)) begin
                ded_count <= ded_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_decode_hamming.sv
// Bench for decode_hamming: spec vectors, flip sweeps over known codewords, hold, reset and counter saturation.
// Expected data follows DECODE_HAMMING_CORRECT_EN the same way the design does.
module tb_decode_hamming;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [12:1] in_data;
    logic        out_valid;
    logic [7:1]  decode_data;
    logic [3:0]  C;
    logic        single_error;
    logic        double_error;
    logic [7:0]  sec_count;
    logic [7:0]  ded_count;

    decode_hamming dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .decode_data  (decode_data),
        .C            (C),
        .single_error (single_error),
        .double_error (double_error),
        .sec_count    (sec_count),
        .ded_count    (ded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:1] cw;
        logic [7:1]  fix;
        logic [7:1]  raw;
        logic [3:0]  c;
        logic        se;
        logic        de;
    } vec_t;

    typedef struct {
        logic [7:1] data;
        logic [3:0] c;
        logic       se;
        logic       de;
        logic [7:0] sec;
        logic [7:0] ded;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   model_sec = 0;
    int   model_ded = 0;

    task automatic check(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [7:1] extract(input logic [12:1] w);
        return {w[11], w[10], w[9], w[7], w[6], w[5], w[3]};
    endfunction

    function automatic logic [7:1] pick(input logic [7:1] fix, input logic [7:1] raw);
`ifdef DECODE_HAMMING_CORRECT_EN
        return fix;
`else
        return raw;
`endif
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        in_valid = 1'b1;
        in_data  = v.cw;
        if (v.se && model_sec < 255) model_sec++;
        if (v.de && model_ded < 255) model_ded++;
        e.data = pick(v.fix, v.raw);
        e.c    = v.c;
        e.se   = v.se;
        e.de   = v.de;
        e.sec  = 8'(model_sec);
        e.ded  = 8'(model_ded);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_check(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_valid", int'(out_valid), 0);
            check("hold_data", int'(decode_data), int'(last_exp.data));
            check("hold_c", int'(C), int'(last_exp.c));
            check("hold_se", int'(single_error), int'(last_exp.se));
            check("hold_de", int'(double_error), int'(last_exp.de));
            check("hold_sec", int'(sec_count), int'(last_exp.sec));
            check("hold_ded", int'(ded_count), int'(last_exp.ded));
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_valid"}, int'(out_valid), 0);
        check({nm, "_data"}, int'(decode_data), 0);
        check({nm, "_c"}, int'(C), 0);
        check({nm, "_se"}, int'(single_error), 0);
        check({nm, "_de"}, int'(double_error), 0);
        check({nm, "_sec"}, int'(sec_count), 0);
        check({nm, "_ded"}, int'(ded_count), 0);
    endtask

    // Scoreboard side: every valid output must match the oldest expected record.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                last_exp = mon_e;
                check("data", int'(decode_data), int'(mon_e.data));
                check("syndrome", int'(C), int'(mon_e.c));
                check("single", int'(single_error), int'(mon_e.se));
                check("double", int'(double_error), int'(mon_e.de));
                check("sec_count", int'(sec_count), int'(mon_e.sec));
                check("ded_count", int'(ded_count), int'(mon_e.ded));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    vec_t        tbl[7];
    logic [12:1] bases[3];
    logic [12:1] w;
    vec_t        v;

    initial begin
        tbl[0] = '{12'b100000000111, 7'b0000001, 7'b0000001, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{12'b100000010111, 7'b0000001, 7'b0000011, 4'b0101, 1'b1, 1'b0};
        tbl[2] = '{12'b000000000111, 7'b0000001, 7'b0000001, 4'b0000, 1'b1, 1'b0};
        tbl[3] = '{12'b100000000100, 7'b0000001, 7'b0000001, 4'b0011, 1'b0, 1'b1};
        tbl[4] = '{12'b000010001111, 7'b0000001, 7'b0000001, 4'b1100, 1'b0, 1'b1};
        tbl[5] = '{12'b000000000000, 7'b0000000, 7'b0000000, 4'b0000, 1'b0, 1'b0};
        tbl[6] = '{12'b111111111111, 7'b1111111, 7'b1111111, 4'b0000, 1'b0, 1'b0};
        bases[0] = 12'b000000000000;
        bases[1] = 12'b100000000111;
        bases[2] = 12'b111111111111;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        check_all_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) drive(tbl[i]);
        idle_check(1);

        // Single flips of clean codewords: syndrome names the flipped position (0 for bit 12).
        for (int b = 0; b < 3; b++) begin
            for (int k = 1; k <= 12; k++) begin
                w = bases[b];
                w[k] = ~w[k];
                v.cw  = w;
                v.fix = extract(bases[b]);
                v.raw = extract(w);
                v.c   = (k <= 11) ? 4'(k) : 4'd0;
                v.se  = 1'b1;
                v.de  = 1'b0;
                drive(v);
            end
        end

        // Double flips: syndrome is the XOR of positions, parity is clean.
        for (int b = 0; b < 3; b++) begin
            for (int i = 1; i <= 11; i++) begin
                for (int j = i + 1; j <= 12; j++) begin
                    w = bases[b];
                    w[i] = ~w[i];
                    w[j] = ~w[j];
                    v.cw  = w;
                    v.fix = extract(w);
                    v.raw = extract(w);
                    v.c   = (j == 12) ? 4'(i) : (4'(i) ^ 4'(j));
                    v.se  = 1'b0;
                    v.de  = 1'b1;
                    drive(v);
                end
            end
        end

        drive(tbl[1]);
        idle_check(2);

        // Reset with a word on the input: it must never come out.
        in_valid = 1'b1;
        in_data  = tbl[3].cw;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        exp_q.delete();
        model_sec = 0;
        model_ded = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all_zero("post_reset");
        end

        drive(tbl[0]);
        drive(tbl[2]);
        idle_check(1);

        for (int n = 0; n < 300; n++) drive(tbl[4]);
        for (int n = 0; n < 260; n++) drive(tbl[1]);
        drive(tbl[0]);
        idle_check(2);
        check("ded_saturated", int'(ded_count), 255);
        check("sec_saturated", int'(sec_count), 255);

        repeat (2) @(posedge clk);
        #1;
        check("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
